// File: rtl/pwm_generator_pkg.sv
// Shared types for the PWM generator: the operating mode decoded from rst/enable.
package pwm_generator_pkg;

  typedef enum logic [1:0] {
    MODE_RESET,
    MODE_IDLE,
    MODE_RUN
  } pwm_mode_e;

  // Reset outranks enable.
  function automatic pwm_mode_e decode_mode(input logic rst, input logic enable);
    if (rst)
      return MODE_RESET;
    else if (!enable)
      return MODE_IDLE;
    else
      return MODE_RUN;
  endfunction

endpackage

// File: rtl/pwm_generator_counter.sv
// Wrapping period counter with synchronous clear and a terminal-count flag.
module pwm_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + ONE;
  end

  // Marks the last cycle of a period while the counter is actually advancing.
  assign tc = enable && (&cnt);

endmodule

// File: rtl/pwm_generator.sv
// PWM generator: period of 2^WIDTH cycles, duty latched at period boundaries.
module pwm_generator
  import pwm_generator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_q;
  logic             tc;
  pwm_mode_e        mode;

  assign mode = decode_mode(rst, enable);

  pwm_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (!enable),
    .cnt    (cnt),
    .tc     (tc)
  );

  // While idle the shadow duty tracks the input so a fresh enable starts with it.
  always_ff @(posedge clk) begin
    case (mode)
      MODE_RESET: begin
        duty_q  <= '0;
        pwm_out <= 1'b0;
      end
      MODE_IDLE: begin
        duty_q  <= duty;
        pwm_out <= 1'b0;
      end
      default: begin
        if (tc)
          duty_q <= duty;
        pwm_out <= (cnt < duty_q);
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: directed period checks plus random duty/enable/reset traffic.
module tb_pwm_generator;

  localparam int WIDTH  = 8;
  localparam int PERIOD = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] duty = '0;
  logic             pwm_out;

  int errors = 0;
  int checks = 0;

  bit exp_q[$];

  // Reference model state: position within the current period and the duty in force.
  int  m_phase = 0;
  int  m_duty  = 0;

  pwm_generator #(
    .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  // Model: high for the first m_duty cycles of each period; duty changes land at period start.
  always @(posedge clk) begin
    bit exp_out;
    if (rst) begin
      m_phase = 0;
      m_duty  = 0;
      exp_out = 1'b0;
    end else if (!enable) begin
      m_phase = 0;
      m_duty  = int'(duty);
      exp_out = 1'b0;
    end else begin
      exp_out = (m_phase < m_duty);
      m_phase = m_phase + 1;
      if (m_phase == PERIOD) begin
        m_phase = 0;
        m_duty  = int'(duty);
      end
    end
    exp_q.push_back(exp_out);
  end

  always @(posedge clk) begin
    bit exp_out;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty t=%0t: no expected value queued", $time);
    end else begin
      exp_out = exp_q.pop_front();
      if (pwm_out !== exp_out) begin
        errors++;
        $display("[TB] FAIL pwm_cycle t=%0t: pwm_out=%b expected=%b", $time, pwm_out, exp_out);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input int d, input int hold);
    @(negedge clk);
    rst    = r;
    enable = e;
    duty   = WIDTH'(d);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Counts high cycles over a window, sampling just after each rising edge.
  task automatic countHigh(input string name, input int ncycles, input int expected);
    int highs = 0;
    repeat (ncycles) begin
      @(posedge clk);
      #1;
      if (pwm_out === 1'b1)
        highs++;
    end
    checkOutput(name, highs, expected);
  endtask

  // Idle one cycle so duty_q picks up the new duty, then start a clean period.
  task automatic restartWith(input int d);
    applyStimulus(1'b0, 1'b0, d, 1);
    @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 0, 2);
    @(posedge clk);
    #1;
    checkOutput("reset_pwm_out", int'(pwm_out), 0);

    applyStimulus(1'b0, 1'b1, 0, 1);
    countHigh("duty0_constant_low", 100, 0);

    restartWith(64);
    countHigh("duty64_two_periods", 2 * PERIOD, 128);

    restartWith(128);
    countHigh("duty128_first_part", 100, 100);
    duty = WIDTH'(192);
    countHigh("duty128_rest_after_midwrite", PERIOD - 100, 28);
    countHigh("duty192_next_period", PERIOD, 192);
    countHigh("duty192_second_period", PERIOD, 192);

    restartWith(255);
    countHigh("duty255_period", PERIOD, 255);
    countHigh("duty255_high_start", 10, 10);
    enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("disable_forces_low", int'(pwm_out), 0);
    checkOutput("disable_clears_cnt", int'(dut.cnt), 0);

    restartWith(128);
    countHigh("pre_reset_high", 50, 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_mid_period_low", int'(pwm_out), 0);
    checkOutput("reset_mid_period_cnt", int'(dut.cnt), 0);
    rst = 1'b0;
    countHigh("post_reset_first_period", PERIOD, 0);
    countHigh("post_reset_clean_period", PERIOD, 128);

    restartWith(1);
    countHigh("duty1_period", PERIOD, 1);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0)
        rst = 1'b1;
      else
        rst = 1'b0;
      if ($urandom_range(0, 63) == 0)
        enable = ~enable;
      if ($urandom_range(0, 7) == 0)
        duty = WIDTH'($urandom_range(0, PERIOD - 1));
    end

    applyStimulus(1'b0, 1'b0, 0, 3);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
